// File: rtl/shared_reg_arb_pkg.sv
// shared_reg_arb_pkg: FSM state encoding, index-width and one-hot helpers for shared_reg_arbiter
package shared_reg_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, DONE = 2'd2} state_t;
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  function automatic logic [31:0] onehot(input int unsigned i);
    return 32'd1 << i;
  endfunction
endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// rr_pick: round-robin winner search from ptr_i upward with wrap; ports req_i/mask_i (candidates), ptr_i (priority start), idx_o (winner), vld_o (any candidate)
module rr_pick
  import shared_reg_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic [N-1:0]  mask_i,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);
  logic [N-1:0] m;
  always_comb begin
    m = req_i & mask_i;
    vld_o = |m;
    idx_o = ptr_i;
    for (int k = N - 1; k >= 0; k--)
      if (m[(int'(ptr_i) + k) % N]) idx_o = IW'((int'(ptr_i) + k) % N);
  end
endmodule

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin arbiter writing one of N requesters' data into a shared W-bit register.
// Ports: clk, reset (sync, active-high), req[N] level requests, data[N*W] packed write data,
// gnt[N] one-hot grant, ack[N] one-hot write-done pulse, Q[W] shared register, busy (FSM not idle).
// Optional ARB_HOLD_EN: a winner still requesting in DONE keeps the grant for up to MAX_HOLD writes.
module shared_reg_arbiter
  import shared_reg_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] data,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   ack,
  output logic [W-1:0]   Q,
  output logic           busy
);
  localparam int IW = idx_w(N);
  localparam int CW = idx_w(MAX_HOLD + 1);
`ifdef ARB_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif
  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, win_q, win_d, pick;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  gnt_q, gnt_d, ack_q, ack_d;
  logic [W-1:0]  q_q, q_d;
  logic          pick_vld;
  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .mask_i({N{1'b1}}),
    .idx_o (pick),
    .vld_o (pick_vld)
  );
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    ack_d   = ack_q;
    q_d     = q_q;
    case (state_q)
      IDLE: if (pick_vld) begin
        state_d = GRANT;
        win_d   = pick;
        cnt_d   = CW'(1);
        gnt_d   = N'(onehot(int'(pick)));
      end
      GRANT: begin
        state_d = DONE;
        q_d     = data[int'(win_q)*W +: W];
        ack_d   = N'(onehot(int'(win_q)));
        gnt_d   = '0;
      end
      DONE: begin
        ack_d = '0;
        // ptr only moves once the winner releases its grant, so a burst keeps priority
        if (HOLD_EN && req[win_q] && cnt_q < CW'(MAX_HOLD)) begin
          state_d = GRANT;
          cnt_d   = cnt_q + CW'(1);
          gnt_d   = N'(onehot(int'(win_q)));
        end else begin
          state_d = IDLE;
          ptr_d   = (win_q == IW'(N - 1)) ? '0 : win_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      q_q     <= q_d;
    end
  end
  assign gnt  = gnt_q;
  assign ack  = ack_q;
  assign Q    = q_q;
  assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter: directed self-checking bench for shared_reg_arbiter (N=4, W=8, MAX_HOLD=2)
module tb_shared_reg_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] data = '0;
  logic [3:0]  gnt, ack;
  logic [7:0]  Q;
  logic        busy;
  int errors = 0;
  int checks = 0;
  shared_reg_arbiter #(.N(4), .W(8), .MAX_HOLD(2)) dut (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .data (data),
    .gnt  (gnt),
    .ack  (ack),
    .Q    (Q),
    .busy (busy)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    reset = 1'b1;
    req   = 4'b1111;
    data  = 32'h13121110;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_q", 32'(Q), 32'h00);
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_ack", 32'(ack), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
    end
    reset = 1'b0;
    req   = 4'b0100;
    data  = 32'h00A50000;
    step();
    chk("single_gnt", 32'(gnt), 32'b0100);
    chk("single_busy", 32'(busy), 32'h1);
    chk("single_ack0", 32'(ack), 32'h0);
    chk("single_q0", 32'(Q), 32'h00);
    step();
    chk("single_q", 32'(Q), 32'hA5);
    chk("single_ack", 32'(ack), 32'b0100);
    chk("single_gnt_off", 32'(gnt), 32'h0);
    req = 4'b0000;
    step();
    chk("single_ack_off", 32'(ack), 32'h0);
    chk("single_idle", 32'(busy), 32'h0);
    chk("single_q_hold", 32'(Q), 32'hA5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    req   = 4'b1111;
    data  = 32'h13121110;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("cont_gnt", 32'(gnt), 32'd1 << (k % 4));
      step();
      chk("cont_q", 32'(Q), 32'h10 + 32'(k % 4));
      chk("cont_ack", 32'(ack), 32'd1 << (k % 4));
      chk("cont_gnt_off", 32'(gnt), 32'h0);
      step();
      chk("cont_ack_off", 32'(ack), 32'h0);
      chk("cont_idle", 32'(busy), 32'h0);
    end
    step();
    chk("mid_gnt", 32'(gnt), 32'b0010);
    reset = 1'b1;
    req   = 4'b0000;
    step();
    chk("mid_q", 32'(Q), 32'h00);
    chk("mid_ack", 32'(ack), 32'h0);
    chk("mid_gnt_off", 32'(gnt), 32'h0);
    chk("mid_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    step();
    chk("mid_q_after", 32'(Q), 32'h00);
    chk("mid_ack_after", 32'(ack), 32'h0);
    chk("mid_idle_after", 32'(busy), 32'h0);
    req = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      step();
      step();
      chk("fair_ack", 32'(ack), (k % 2 == 1) ? 32'b0010 : 32'b0001);
      chk("fair_q", 32'(Q), (k % 2 == 1) ? 32'h11 : 32'h10);
      step();
    end
    reset = 1'b1;
    req   = 4'b0000;
    step();
    reset = 1'b0;
    req   = 4'b1010;
    step();
    chk("hold_gnt1", 32'(gnt), 32'b0010);
    step();
    chk("hold_ack1", 32'(ack), 32'b0010);
    chk("hold_q1", 32'(Q), 32'h11);
    step();
`ifdef ARB_HOLD_EN
    chk("hold_regnt", 32'(gnt), 32'b0010);
    chk("hold_regnt_ack", 32'(ack), 32'h0);
    chk("hold_busy", 32'(busy), 32'h1);
    step();
    chk("hold_ack2", 32'(ack), 32'b0010);
    chk("hold_q2", 32'(Q), 32'h11);
    step();
    chk("hold_end_ack", 32'(ack), 32'h0);
    chk("hold_end_idle", 32'(busy), 32'h0);
    chk("hold_end_gnt", 32'(gnt), 32'h0);
`else
    chk("nohold_idle", 32'(busy), 32'h0);
    chk("nohold_gnt", 32'(gnt), 32'h0);
    chk("nohold_ack", 32'(ack), 32'h0);
`endif
    step();
    chk("next_gnt3", 32'(gnt), 32'b1000);
    step();
    chk("next_ack3", 32'(ack), 32'b1000);
    chk("next_q3", 32'(Q), 32'h13);
    req = 4'b0000;
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
